// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory controller: FSM states, request owner,
// IO window selector and access-length codes.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSB = 1'b1
  } owner_t;

  localparam logic [1:0] IO_SEL_DEF = 2'b11;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  // Any length code other than byte/half collapses to a full word.
  function automatic logic [2:0] norm_len(input logic [2:0] len);
    case (len)
      LEN_B:   return LEN_B;
      LEN_H:   return LEN_H;
      default: return LEN_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Single-port byte-wide memory sequencer arbitrating instruction fetch and
// the load/store buffer; assembles little-endian words from RAM bytes.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_SEL = IO_SEL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rollback,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              lsb_req,
  input  logic              lsb_wr,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [2:0]        lsb_len,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_done,
  output logic [31:0]       lsb_rdata
);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        len_q, len_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       buf_q, buf_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d, a_hold_q;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              if_done_q, if_done_d;
  logic              lsb_done_q, lsb_done_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       lsb_rdata_q, lsb_rdata_d;
  logic [1:0]        rd_idx;
  logic [2:0]        cnt_inc;
  logic              io_stall;

  assign rd_idx   = cnt_q[1:0] - 2'd1;
  assign cnt_inc  = cnt_q + 3'd1;
  assign io_stall = (addr_q[17:16] == IO_SEL) && io_buffer_full;

  // While frozen, re-present the last address so mem_din on resume still
  // carries the byte the sequence was about to capture.
  assign mem_a     = rdy ? mem_a_q : a_hold_q;
  assign mem_wr    = mem_wr_q & rdy;
  assign mem_dout  = mem_dout_q;
  assign if_done   = if_done_q & rdy & ~rollback;
  assign lsb_done  = lsb_done_q & rdy;
  assign if_data   = if_data_q;
  assign lsb_rdata = lsb_rdata_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    len_d       = len_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = 1'b0;
    if_done_d   = 1'b0;
    lsb_done_d  = 1'b0;
    if_data_d   = if_data_q;
    lsb_rdata_d = lsb_rdata_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 3'd0;
        buf_d = 32'd0;
        if (rollback) begin
          state_d = S_IDLE;
        end else if (lsb_req) begin
          owner_d = OWN_LSB;
          addr_d  = lsb_addr;
          len_d   = norm_len(lsb_len);
          wdata_d = lsb_wdata;
          mem_a_d = lsb_addr;
          if (lsb_wr) begin
            state_d = S_WR;
            // Byte 0 may go out next cycle only if the IO buffer has room now.
            if ((lsb_addr[17:16] == IO_SEL) && io_buffer_full) begin
              cnt_d = 3'd0;
            end else begin
              mem_wr_d   = 1'b1;
              mem_dout_d = lsb_wdata[7:0];
              cnt_d      = 3'd1;
            end
          end else begin
            state_d = S_RD;
          end
        end else if (if_req) begin
          owner_d = OWN_IF;
          addr_d  = if_addr;
          len_d   = LEN_W;
          mem_a_d = if_addr;
          state_d = S_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (rollback) begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end else begin
          // cnt counts cycles in RD; byte cnt-1 arrives on mem_din now.
          if (cnt_q != 3'd0) begin
            buf_d[{rd_idx, 3'b000} +: 8] = mem_din;
          end else begin
            buf_d = buf_q;
          end
          if (cnt_q == len_q) begin
            state_d = S_DONE;
            cnt_d   = 3'd0;
            if (owner_q == OWN_IF) begin
              if_done_d = 1'b1;
              if_data_d = buf_d;
            end else begin
              lsb_done_d  = 1'b1;
              lsb_rdata_d = buf_d;
            end
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc < len_q) begin
              mem_a_d = addr_q + {{(ADDR_W-3){1'b0}}, cnt_inc};
            end else begin
              mem_a_d = mem_a_q;
            end
          end
        end
      end
      S_WR: begin
        if (cnt_q == len_q) begin
          state_d    = S_DONE;
          cnt_d      = 3'd0;
          lsb_done_d = 1'b1;
        end else if (io_stall) begin
          cnt_d = cnt_q;
        end else begin
          mem_wr_d   = 1'b1;
          mem_a_d    = addr_q + {{(ADDR_W-3){1'b0}}, cnt_q};
          mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          cnt_d      = cnt_inc;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; everything freezes while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      addr_q      <= '0;
      len_q       <= 3'd0;
      wdata_q     <= 32'd0;
      cnt_q       <= 3'd0;
      buf_q       <= 32'd0;
      mem_a_q     <= '0;
      a_hold_q    <= '0;
      mem_dout_q  <= 8'd0;
      mem_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      if_data_q   <= 32'd0;
      lsb_rdata_q <= 32'd0;
    end else if (rdy) begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      mem_a_q     <= mem_a_d;
      a_hold_q    <= mem_a_q;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      if_done_q   <= if_done_d;
      lsb_done_q  <= lsb_done_d;
      if_data_q   <= if_data_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: synchronous byte RAM model, cycle-exact checks
// of bus activity, done pulses and assembled data.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_data;
  logic        lsb_req, lsb_wr, lsb_done;
  logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
  logic [2:0]  lsb_len;

  logic [7:0]  ram [0:65535];
  int          wr_count = 0;
  int          total = 0;
  int          bad = 0;
  int          w0;
  logic [31:0] wv;

  mem_ctrl #(.ADDR_W(32), .IO_SEL(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata)
  );

  always #5 clk = ~clk;

  // RAM: byte for the address seen this cycle appears on mem_din next cycle.
  always @(posedge clk) begin
    mem_din <= ram[mem_a[15:0]];
    if (!rst && mem_wr) wr_count <= wr_count + 1;
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    lsb_req = 1'b0; lsb_wr = 1'b0; lsb_addr = 32'd0; lsb_len = 3'd0; lsb_wdata = 32'd0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05; ram[16'h0102] = 8'h00; ram[16'h0103] = 8'h00;
    ram[16'h0200] = 8'hEF; ram[16'h0201] = 8'hBE; ram[16'h0202] = 8'hAD; ram[16'h0203] = 8'hDE;
    ram[16'h0040] = 8'h93; ram[16'h0041] = 8'h00; ram[16'h0042] = 8'h10; ram[16'h0043] = 8'h00;
    ram[16'h0500] = 8'hEF; ram[16'h0501] = 8'hBE;
    ram[16'hFFFF] = 8'h5A; ram[16'h0000] = 8'hC3;

    nxt(); nxt();
    rst = 1'b0;
    #1;
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_if_done", {31'd0, if_done}, 32'd0);
    chk("rst_lsb_done", {31'd0, lsb_done}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_lsb_rdata", lsb_rdata, 32'd0);

    // IF fetch at 0x100
    if_req = 1'b1; if_addr = 32'h100;
    for (int k = 0; k < 4; k++) begin
      nxt();
      chk("if_mem_a", mem_a, 32'h100 + k);
      chk("if_mem_wr", {31'd0, mem_wr}, 32'd0);
    end
    nxt(); chk("if_done_early", {31'd0, if_done}, 32'd0);
    nxt(); chk("if_done", {31'd0, if_done}, 32'd1);
    chk("if_data", if_data, 32'h00000513);
    if_req = 1'b0;
    nxt(); chk("if_done_pulse", {31'd0, if_done}, 32'd0);

    // Simultaneous requests: LSB load wins
    if_req = 1'b1; if_addr = 32'h100;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h200; lsb_len = 3'd4;
    nxt(); chk("arb_mem_a", mem_a, 32'h200);
    repeat (4) nxt();
    chk("arb_lsb_early", {31'd0, lsb_done}, 32'd0);
    nxt(); chk("arb_lsb_done", {31'd0, lsb_done}, 32'd1);
    chk("arb_lsb_rdata", lsb_rdata, 32'hDEADBEEF);
    chk("arb_if_idle", {31'd0, if_done}, 32'd0);
    lsb_req = 1'b0;
    nxt();
    nxt(); chk("arb_if_mem_a", mem_a, 32'h100);
    repeat (4) nxt();
    chk("arb_if_early", {31'd0, if_done}, 32'd0);
    nxt(); chk("arb_if_done", {31'd0, if_done}, 32'd1);
    chk("arb_if_data", if_data, 32'h00000513);
    if_req = 1'b0;
    nxt();

    // IO store stalled by a full IO buffer
    w0 = wr_count;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h30000; lsb_len = 3'd1;
    lsb_wdata = 32'hAABBCC41; io_buffer_full = 1'b1;
    nxt(); chk("io_stall1", {31'd0, mem_wr}, 32'd0);
    nxt(); chk("io_stall2", {31'd0, mem_wr}, 32'd0);
    nxt(); io_buffer_full = 1'b0; #1;
    chk("io_stall3", {31'd0, mem_wr}, 32'd0);
    nxt(); chk("io_wr", {31'd0, mem_wr}, 32'd1);
    chk("io_mem_a", mem_a, 32'h30000);
    chk("io_dout", {24'd0, mem_dout}, 32'h41);
    nxt(); chk("io_done", {31'd0, lsb_done}, 32'd1);
    chk("io_wr_off", {31'd0, mem_wr}, 32'd0);
    chk("io_wr_count", wr_count - w0, 32'd1);
    lsb_req = 1'b0;
    nxt();

    // Rollback aborts an IF read, then a fresh fetch at 0x40
    if_req = 1'b1; if_addr = 32'h100;
    nxt(); nxt(); nxt();
    rollback = 1'b1; if_req = 1'b0; #1;
    chk("rb_if_done_t3", {31'd0, if_done}, 32'd0);
    nxt();
    rollback = 1'b0; if_req = 1'b1; if_addr = 32'h40; #1;
    chk("rb_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rb_if_done_t4", {31'd0, if_done}, 32'd0);
    nxt(); chk("rb_new_mem_a", mem_a, 32'h40);
    repeat (4) nxt();
    chk("rb_no_stale_done", {31'd0, if_done}, 32'd0);
    nxt(); chk("rb_new_done", {31'd0, if_done}, 32'd1);
    chk("rb_new_data", if_data, 32'h00100093);
    if_req = 1'b0;
    nxt();

    // Rollback during a word store does not cut it short
    w0 = wr_count; wv = 32'h11223344;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h1000; lsb_len = 3'd4; lsb_wdata = wv;
    for (int k = 0; k < 4; k++) begin
      nxt();
      rollback = (k == 0);
      #1;
      chk("sw_mem_wr", {31'd0, mem_wr}, 32'd1);
      chk("sw_mem_a", mem_a, 32'h1000 + k);
      chk("sw_dout", {24'd0, mem_dout}, (wv >> (8 * k)) & 32'hFF);
    end
    nxt(); chk("sw_done", {31'd0, lsb_done}, 32'd1);
    chk("sw_wr_count", wr_count - w0, 32'd4);
    lsb_req = 1'b0; rollback = 1'b0;
    nxt();

    // rdy low for two cycles in the middle of a halfword load
    w0 = wr_count;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h500; lsb_len = 3'd2;
    nxt(); chk("lh_mem_a", mem_a, 32'h500);
    nxt(); rdy = 1'b0; #1;
    chk("lh_frz_wr1", {31'd0, mem_wr}, 32'd0);
    nxt(); chk("lh_frz_wr2", {31'd0, mem_wr}, 32'd0);
    chk("lh_frz_done", {31'd0, lsb_done}, 32'd0);
    nxt(); rdy = 1'b1;
    nxt(); #1; chk("lh_done_early", {31'd0, lsb_done}, 32'd0);
    nxt(); chk("lh_done", {31'd0, lsb_done}, 32'd1);
    chk("lh_rdata", lsb_rdata, 32'h0000BEEF);
    chk("lh_no_writes", wr_count - w0, 32'd0);
    lsb_req = 1'b0;
    nxt();

    // Address wrap across the top of the address space
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'hFFFFFFFF; lsb_len = 3'd2;
    nxt(); chk("wrap_a0", mem_a, 32'hFFFFFFFF);
    nxt(); chk("wrap_a1", mem_a, 32'h00000000);
    nxt();
    nxt(); chk("wrap_done", {31'd0, lsb_done}, 32'd1);
    chk("wrap_rdata", lsb_rdata, 32'h0000C35A);
    lsb_req = 1'b0;
    nxt();

    // Unsupported length code behaves as a word
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h200; lsb_len = 3'd5;
    repeat (5) nxt();
    chk("len5_early", {31'd0, lsb_done}, 32'd0);
    nxt(); chk("len5_done", {31'd0, lsb_done}, 32'd1);
    chk("len5_rdata", lsb_rdata, 32'hDEADBEEF);
    lsb_req = 1'b0;
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port memory controller and arbiter between instruction fetch (IF) and the load/store buffer (LSB).
- Sequences the byte-wide RAM/IO interface for 4-byte instruction reads and 1/2/4-byte loads and stores.
- Returns assembled little-endian words to the requester.
- Sits between the IF/LSB units and the top-level memory bus.

Parameters:
- ADDR_W, 32, address width.
- IO_SEL, 2'b11, value of addr[17:16] that marks an IO-mapped address.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rdy  in  1  global enable; low freezes all state
- rollback  in  1  misprediction flush from ROB
- mem_din  in  8  RAM read byte; valid one cycle after its address
- mem_dout  out  8  RAM write byte
- mem_a  out  ADDR_W  RAM byte address
- mem_wr  out  1  write strobe
- io_buffer_full  in  1  IO write buffer full
- if_req  in  1  IF read request (level)
- if_addr  in  ADDR_W  fetch address
- if_done  out  1  one-cycle pulse, if_data valid
- if_data  out  32  fetched instruction
- lsb_req  in  1  LSB request (level)
- lsb_wr  in  1  1 = store, 0 = load
- lsb_addr  in  ADDR_W  byte address
- lsb_len  in  3  byte count: 1, 2 or 4
- lsb_wdata  in  32  store data; low lsb_len bytes used
- lsb_done  out  1  one-cycle pulse
- lsb_rdata  out  32  load data, zero-extended; sign extension is done in the LSB

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset: state=IDLE, mem_a=0, mem_dout=0, mem_wr=0, if_done=0, lsb_done=0, if_data=0, lsb_rdata=0, byte counter=0.
- States:
  - IDLE: samples requests.
  - RD: read in progress, owner IF or LSB.
  - WR: store in progress.
  - DONE: done cycle; requests are not sampled.
- Arbitration in IDLE: fixed priority, lsb_req over if_req. Address, length, wdata and owner are latched in the accept cycle T.
- Read of N bytes (IF uses N=4):
  - mem_a = addr+k in cycles T+1..T+N, mem_wr=0.
  - Byte k captured from mem_din in cycle T+2+k.
  - done and data are registered and visible in cycle T+N+2, state DONE.
  - Byte k lands in data[8k+7:8k]; unused upper bytes are 0.
- Write of N bytes:
  - mem_wr=1, mem_a=addr+k, mem_dout=wdata[8k+7:8k] in cycles T+1..T+N.
  - lsb_done in T+N+1.
  - mem_wr=0 in every cycle outside WR.
- IO stall: in WR with addr[17:16]==IO_SEL, byte k is issued only if io_buffer_full=0 in the preceding cycle. Otherwise mem_wr=0 that cycle and the counter holds. Reads are never stalled.
- Handshake:
  - Requester holds req and its fields stable until it sees done.
  - Requester drops req by the cycle after done.
  - DONE always returns to IDLE in the next cycle, so back-to-back requests are accepted in D+1 at the earliest.
- rollback=1 (with rdy):
  - State RD (either owner): go to IDLE, no done pulse, partial data discarded.
  - State DONE with an IF owner: if_done is forced 0.
  - State WR: continues to completion, because stores are committed.
  - State IDLE: requests are not accepted in that cycle.
- rdy=0: state, counter and data registers hold. mem_wr is driven 0 and done outputs are held low. The sequence resumes on the cycle rdy returns.
- Address arithmetic: addr+k is computed modulo 2^ADDR_W; wrap is allowed.
- lsb_len values other than 1/2/4 are treated as 4.

Decomposition:
- Shared header next to op_map.v holds:
  - state encodings IDLE/RD/WR/DONE;
  - owner encoding IF/LSB;
  - IO_SEL constant;
  - length encodings LEN_B=1, LEN_H=2, LEN_W=4.
- No sub-module: the byte counter and shift-assemble logic stay inline.

Test Plan:
- IF read: if_req, if_addr=0x100, RAM bytes 13,05,00,00 → mem_a 0x100..0x103 in T+1..T+4; if_done in T+6 with if_data=0x00000513.
- Simultaneous if_req and lsb_req (LW at 0x200 = 0xDEADBEEF) → LSB served first, lsb_rdata=0xDEADBEEF at T+6. IF is accepted in the cycle after DONE and completes 6 cycles later.
- SB 0x30000 data 0x41 with io_buffer_full high for 3 cycles → mem_wr stays 0 for 3 cycles, then a single write of mem_dout=0x41, mem_a=0x30000; lsb_done the cycle after.
- rollback during an IF read at T+3 → no if_done, state IDLE at T+4, mem_wr=0. A new if_req at 0x40 then completes normally.
- rollback during SW at 0x1000 (0x11223344) → all 4 bytes written (44,33,22,11 at 0x1000..0x1003) and lsb_done asserted.
- rdy low for 2 cycles mid LH (0x500 = 0xBEEF) → sequence stretched by 2 cycles, lsb_rdata=0x0000BEEF, no extra writes.
